// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, opcode and
// funct values, ALU operation codes, datapath select encodings and the
// control-word layout.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Registered control word; pc_write and branch only feed the pc_en equation.
  typedef struct packed {
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct decoder: maps an R-type funct field to the ALU operation
// and flags whether the funct is one the datapath supports.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 4
) (
  input  logic [OPW-1:0]    funct,
  output logic [ALUOPW-1:0] alu_op,
  output logic              legal
);

  // Unsupported funct values fall back to ADD and clear legal.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control FSM. Sequences fetch, decode, execute, memory
// and writeback states and drives the datapath selects and write enables from
// the state register. Also counts retired instructions.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  output logic              i_or_d,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        pc_src,
  output logic              pc_en,
  output logic              illegal,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  retired
);

  state_t            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [ALUOPW-1:0] fn_alu_op;
  logic              fn_legal;
  logic              op_legal;

  mc_alu_decoder #(.OPW(OPW), .ALUOPW(ALUOPW)) u_alu_dec (
    .funct  (funct),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  // Control word for a given state; EXEC takes its ALU op from the funct decoder.
  function automatic ctrl_t decode_ctrl(state_t s, logic [3:0] exec_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:  c.i_or_d = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = exec_op;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.branch    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Opcodes the FSM knows how to sequence.
  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  end

  // Next-state selection; illegal opcodes/functs abandon the instruction.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = fn_legal ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, registered control word and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d, 4'(fn_alu_op));
      if (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP})
        retired <= retired + 1'b1;
    end
  end

  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_write  = ctrl_q.mem_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ALUOPW'(ctrl_q.alu_op);
  assign pc_src     = ctrl_q.pc_src;
  assign state      = state_q;
  assign pc_en      = ctrl_q.pc_write | (ctrl_q.branch & zero);
  assign illegal    = ((state_q == S_DECODE) && !op_legal) ||
                      ((state_q == S_EXEC) && !fn_legal);

endmodule
